// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear quad fetch blocks.
package bilinear_pkg;

  // Pixel width of the image SRAM.
  localparam int PIX_BITS = 8;

  // Default geometry shared by the fetch top and the address generator.
  localparam int DEF_ADDR_BITS  = 19;
  localparam int DEF_COORD_BITS = 10;

  // Fetch sequencer states: four address issues, one trailing capture, output hold.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    RD3   = 3'd4,
    DRAIN = 3'd5,
    OUT   = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/bilinear_addr_gen.sv
// Combinational clamp and address generator for a 2x2 pixel neighbourhood.
// Coordinates past the image edge clamp to the last column/row, never wrap.
module bilinear_addr_gen
  import bilinear_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int COORD_BITS = DEF_COORD_BITS,
  parameter int BASE_ADDR  = 0
) (
  input  logic [COORD_BITS-1:0] req_x,
  input  logic [COORD_BITS-1:0] req_y,
  input  logic [COORD_BITS-1:0] img_w,
  input  logic [COORD_BITS-1:0] img_h,
  output logic [ADDR_BITS-1:0]  addr00,
  output logic [ADDR_BITS-1:0]  addr01,
  output logic [ADDR_BITS-1:0]  addr10,
  output logic [ADDR_BITS-1:0]  addr11
);

  // Row base is formed at full product width before truncation to the SRAM address.
  localparam int PROD_BITS = 2 * COORD_BITS;
  localparam int FULL_BITS = ((ADDR_BITS > PROD_BITS) ? ADDR_BITS : PROD_BITS) + 1;

  logic [COORD_BITS-1:0] x_max;
  logic [COORD_BITS-1:0] y_max;
  logic [COORD_BITS-1:0] cx0;
  logic [COORD_BITS-1:0] cx1;
  logic [COORD_BITS-1:0] cy0;
  logic [COORD_BITS-1:0] cy1;
  logic [ADDR_BITS-1:0]  row0;
  logic [ADDR_BITS-1:0]  row1;

  // Clamp both coordinates and their +1 neighbours, then build the four addresses.
  always_comb begin
    x_max = img_w - COORD_BITS'(1);
    y_max = img_h - COORD_BITS'(1);
    cx0   = (req_x > x_max) ? x_max : req_x;
    cy0   = (req_y > y_max) ? y_max : req_y;
    cx1   = (cx0 < x_max) ? (cx0 + COORD_BITS'(1)) : x_max;
    cy1   = (cy0 < y_max) ? (cy0 + COORD_BITS'(1)) : y_max;
    row0  = ADDR_BITS'(FULL_BITS'(BASE_ADDR) + FULL_BITS'(cy0) * FULL_BITS'(img_w));
    row1  = ADDR_BITS'(FULL_BITS'(BASE_ADDR) + FULL_BITS'(cy1) * FULL_BITS'(img_w));
    addr00 = row0 + ADDR_BITS'(cx0);
    addr01 = row0 + ADDR_BITS'(cx1);
    addr10 = row1 + ADDR_BITS'(cx0);
    addr11 = row1 + ADDR_BITS'(cx1);
  end

endmodule

// File: rtl/bilinear_quad_fetch.sv
// Fetches a clamped 2x2 pixel quad from a 1-cycle-latency image SRAM with four
// sequential reads and hands it, with its sideband tag, to the interpolator.
module bilinear_quad_fetch
  import bilinear_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int COORD_BITS = DEF_COORD_BITS,
  parameter int TAG_BITS   = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_BITS-1:0] img_w,
  input  logic [COORD_BITS-1:0] img_h,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [COORD_BITS-1:0] req_x,
  input  logic [COORD_BITS-1:0] req_y,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  input  logic [PIX_BITS-1:0]   mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_BITS-1:0]   p00,
  output logic [PIX_BITS-1:0]   p01,
  output logic [PIX_BITS-1:0]   p10,
  output logic [PIX_BITS-1:0]   p11,
  output logic [TAG_BITS-1:0]   out_tag
);

  fetch_state_t state;
  fetch_state_t next_state;

  logic [ADDR_BITS-1:0] gen_a00;
  logic [ADDR_BITS-1:0] gen_a01;
  logic [ADDR_BITS-1:0] gen_a10;
  logic [ADDR_BITS-1:0] gen_a11;
  logic [ADDR_BITS-1:0] a01_q;
  logic [ADDR_BITS-1:0] a10_q;
  logic [ADDR_BITS-1:0] a11_q;

  bilinear_addr_gen #(
    .ADDR_BITS (ADDR_BITS),
    .COORD_BITS(COORD_BITS),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .req_x (req_x),
    .req_y (req_y),
    .img_w (img_w),
    .img_h (img_h),
    .addr00(gen_a00),
    .addr01(gen_a01),
    .addr10(gen_a10),
    .addr11(gen_a11)
  );

  assign req_ready = (state == IDLE);
  assign out_valid = (state == OUT);
  assign mem_we    = 1'b0;

  // State register; reset abandons any quad in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: one cycle per read slot, then hold in OUT until the consumer takes the quad.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = RD0;
      RD0:     next_state = RD1;
      RD1:     next_state = RD2;
      RD2:     next_state = RD3;
      RD3:     next_state = DRAIN;
      DRAIN:   next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address issue and pixel capture; each pixel is taken one slot after its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      a01_q    <= '0;
      a10_q    <= '0;
      a11_q    <= '0;
      p00      <= '0;
      p01      <= '0;
      p10      <= '0;
      p11      <= '0;
      out_tag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= gen_a00;
            a01_q    <= gen_a01;
            a10_q    <= gen_a10;
            a11_q    <= gen_a11;
            out_tag  <= req_tag;
          end
        end
        RD0: begin
          mem_addr <= a01_q;
        end
        RD1: begin
          p00      <= mem_rdata;
          mem_addr <= a10_q;
        end
        RD2: begin
          p01      <= mem_rdata;
          mem_addr <= a11_q;
        end
        RD3: begin
          p10 <= mem_rdata;
        end
        DRAIN: begin
          p11 <= mem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
